// File: rtl/noc_arb_requester.sv
// noc_arb_requester: buffers one source's flits and streams whole packets to a held-grant arbiter
module noc_arb_requester #(
    parameter int FLIT_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLIT_WIDTH-1:0] in_data,
    input  logic                  in_tail,
    output logic                  request,
    input  logic                  grant,
    output logic                  free,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLIT_WIDTH-1:0] out_data,
    output logic                  out_tail,
    output logic [CNT_WIDTH-1:0]  pkt_sent
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW:0]         r_wptr;
    logic [AW:0]         r_rptr;
    logic [FLIT_WIDTH:0] r_mem [FIFO_DEPTH];
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;

    assign w_empty  = r_wptr == r_rptr;
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push   = in_valid && !w_full;
    assign w_pop    = out_valid && out_ready;
    assign in_ready = !w_full;
    assign {out_tail, out_data} = r_mem[r_rptr[AW-1:0]];

    // flit storage, {tail,data}; contents need no reset since pointers gate visibility
    always_ff @(posedge noc_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {in_tail, in_data};
    end

    // FIFO pointers with wrap flag in the MSB
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // state register and completed-packet counter
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_state  <= IDLE;
            pkt_sent <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (free) pkt_sent <= pkt_sent + 1'b1;
        end
    end

    // request only from registered state; in SEND stream until the tail handshake releases the grant
    always_comb begin
        w_state_nxt = r_state;
        request     = 1'b0;
        out_valid   = 1'b0;
        free        = 1'b0;
        if (r_state == IDLE) begin
            request = !w_empty;
            if (request && grant) w_state_nxt = SEND;
        end else begin
            out_valid = !w_empty;
            free      = out_valid && out_ready && out_tail;
            if (free) w_state_nxt = IDLE;
        end
    end
endmodule
